// File: rtl/pipe_world_model.sv
// Grid-map plant model of the pipe interior: holds the map and robot pose, executes
// front/turn/remove commands and drives the sensor bits back to the controller.
module pipe_world_model #(
  parameter int COLS          = 8,
  parameter int ROWS          = 8,
  parameter int XW            = 3,
  parameter int YW            = 3,
  parameter int REMOVE_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          map_we,
  input  logic [XW-1:0] map_x,
  input  logic [YW-1:0] map_y,
  input  logic [1:0]    map_data,
  input  logic          start,
  input  logic [XW-1:0] start_x,
  input  logic [YW-1:0] start_y,
  input  logic [1:0]    start_dir,
  input  logic          front,
  input  logic          turn,
  input  logic          remove,
  output logic          head,
  output logic          left,
  output logic          under,
  output logic          barrier,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [1:0]    dir,
  output logic          busy,
  output logic          done,
  output logic          crash,
  output logic          cmd_err,
  output logic [15:0]   step_count,
  output logic [7:0]    trash_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REMOVING, S_DONE} state_t;

  localparam logic [1:0] C_FREE  = 2'b00;
  localparam logic [1:0] C_WALL  = 2'b01;
  localparam logic [1:0] C_TRASH = 2'b10;
  localparam logic [1:0] C_EXIT  = 2'b11;

  localparam int            CW      = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
  localparam logic [CW-1:0] RM_LOAD = CW'(REMOVE_CYCLES - 1);
  localparam logic [CW-1:0] RM_ONE  = CW'(1);
  localparam logic [XW:0]   COLS_X  = (XW+1)'(COLS);
  localparam logic [YW:0]   ROWS_Y  = (YW+1)'(ROWS);
  localparam logic [XW:0]   ONE_X   = (XW+1)'(1);
  localparam logic [YW:0]   ONE_Y   = (YW+1)'(1);

  state_t        state_q, state_d;
  logic [1:0]    map_q [ROWS][COLS];
  logic [XW-1:0] pos_x_q;
  logic [YW-1:0] pos_y_q;
  logic [1:0]    dir_q;
  logic [15:0]   step_q;
  logic [7:0]    trash_q;
  logic          crash_q, err_q;
  logic [CW-1:0] rm_cnt_q;

  // Neighbour coordinates are one bit wider so that stepping off either edge
  // (including the 0-1 underflow) lands on a value >= the grid size.
  function automatic logic [XW:0] nb_x(input logic [XW-1:0] x, input logic [1:0] d);
    case (d)
      2'd1:    nb_x = {1'b0, x} + ONE_X;
      2'd3:    nb_x = {1'b0, x} - ONE_X;
      default: nb_x = {1'b0, x};
    endcase
  endfunction

  function automatic logic [YW:0] nb_y(input logic [YW-1:0] y, input logic [1:0] d);
    case (d)
      2'd0:    nb_y = {1'b0, y} - ONE_Y;
      2'd2:    nb_y = {1'b0, y} + ONE_Y;
      default: nb_y = {1'b0, y};
    endcase
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [XW:0] fx, lx;
  logic [YW:0] fy, ly;
  logic [1:0]  ldir;
  logic        front_in, left_in, active;
  logic [1:0]  front_cell, left_cell, cur_cell;

  // Sensors look only at registered pose and map; cells off the grid read as WALL.
  always_comb begin
    ldir       = dir_q - 2'd1;
    fx         = nb_x(pos_x_q, dir_q);
    fy         = nb_y(pos_y_q, dir_q);
    lx         = nb_x(pos_x_q, ldir);
    ly         = nb_y(pos_y_q, ldir);
    front_in   = (fx < COLS_X) && (fy < ROWS_Y);
    left_in    = (lx < COLS_X) && (ly < ROWS_Y);
    front_cell = front_in ? map_q[fy[YW-1:0]][fx[XW-1:0]] : C_WALL;
    left_cell  = left_in  ? map_q[ly[YW-1:0]][lx[XW-1:0]] : C_WALL;
    cur_cell   = map_q[pos_y_q][pos_x_q];
  end

  assign active  = (state_q != S_IDLE);
  assign head    = active && (front_cell == C_WALL);
  assign barrier = active && (front_cell == C_TRASH);
  assign left    = active && (left_cell == C_WALL);
  assign under   = active && (cur_cell == C_EXIT);

  logic do_write, do_start, do_move, do_turn, do_crash, do_err, do_rm_load, do_rm_done;
  logic multi_cmd;

  assign multi_cmd = (front & turn) | (front & remove) | (turn & remove);

  always_ff @(posedge clock) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    do_write   = 1'b0;
    do_start   = 1'b0;
    do_move    = 1'b0;
    do_turn    = 1'b0;
    do_crash   = 1'b0;
    do_err     = 1'b0;
    do_rm_load = 1'b0;
    do_rm_done = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        done     = (state_q == S_DONE);
        do_write = map_we && ({1'b0, map_x} < COLS_X) && ({1'b0, map_y} < ROWS_Y);
        if (start) begin
          do_start = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (cur_cell == C_EXIT) begin
          state_d = S_DONE;
        end else if (multi_cmd) begin
          do_err = 1'b1;
        end else if (front) begin
          if (front_cell == C_FREE || front_cell == C_EXIT) do_move = 1'b1;
          else                                               do_crash = 1'b1;
        end else if (turn) begin
          do_turn = 1'b1;
        end else if (remove) begin
          if (front_cell == C_TRASH) begin
            do_rm_load = 1'b1;
            state_d    = S_REMOVING;
          end else begin
            do_err = 1'b1;
          end
        end
      end
      S_REMOVING: begin
        busy = 1'b1;
        if (rm_cnt_q == '0) begin
          do_rm_done = 1'b1;
          state_d    = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          map_q[r][c] <= C_FREE;
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      dir_q    <= 2'd0;
      step_q   <= '0;
      trash_q  <= '0;
      crash_q  <= 1'b0;
      err_q    <= 1'b0;
      rm_cnt_q <= '0;
    end else begin
      if (do_write) map_q[map_y][map_x] <= map_data;
      if (do_start) begin
        pos_x_q <= start_x;
        pos_y_q <= start_y;
        dir_q   <= start_dir;
        step_q  <= '0;
        trash_q <= '0;
        crash_q <= 1'b0;
        err_q   <= 1'b0;
      end
      if (do_move) begin
        pos_x_q <= fx[XW-1:0];
        pos_y_q <= fy[YW-1:0];
        step_q  <= sat_inc16(step_q);
      end
      if (do_turn) begin
        dir_q  <= dir_q + 2'd1;
        step_q <= sat_inc16(step_q);
      end
      if (do_crash) crash_q <= 1'b1;
      if (do_err)   err_q   <= 1'b1;
      if (do_rm_load)
        rm_cnt_q <= RM_LOAD;
      else if (state_q == S_REMOVING && rm_cnt_q != '0)
        rm_cnt_q <= rm_cnt_q - RM_ONE;
      // Pose is frozen while removing, so the front cell is still the trash cell.
      if (do_rm_done) begin
        map_q[fy[YW-1:0]][fx[XW-1:0]] <= C_FREE;
        trash_q <= sat_inc8(trash_q);
      end
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign dir         = dir_q;
  assign crash       = crash_q;
  assign cmd_err     = err_q;
  assign step_count  = step_q;
  assign trash_count = trash_q;

endmodule
